bus_master_ctrl: RTL and testbench
==================================

// Module: bus_master_ctrl
// PURPOSE
//  Single-outstanding bus master sitting directly upstream of the slave read-back mux.
//  Accepts CPU requests (valid/ready), decodes the address into one of 8 active-low slave chip
//  selects, and holds the access until the muxed m_rdyn goes low. It then returns read data
//  or an error (decode miss / timeout) as a one-cycle response pulse.
// PARAMETERS
//  SEL_LSB   28   LSB of 3-bit slave-select field req_addr[SEL_LSB+2:SEL_LSB]
//  TIMEOUT   256  max cycles in ACCESS awaiting m_rdyn==0; 0 disables timeout
//  CNT_W     9    timeout counter width; must hold TIMEOUT
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  req_valid    in   1   CPU request valid
//  req_ready    out  1   controller can accept a request (IDLE)
//  req_addr     in   32  byte address
//  req_wr       in   1   1=write, 0=read
//  req_wdata    in   32  write data
//  rsp_valid    out  1   one-cycle response strobe (no backpressure)
//  rsp_rdata    out  32  read data (0 on writes/errors)
//  rsp_err      out  1   qualifies rsp_valid: decode miss or timeout
//  bus_addr     out  32  address to slaves, held through ACCESS
//  bus_wr       out  1   write enable to slaves, held through ACCESS
//  bus_wdata    out  32  write data to slaves, held through ACCESS
//  s0_csn..s7_csn out 1 each  active-low slave selects, at most one low
//  m_rdata      in   32  read data from slave mux
//  m_rdyn       in   1   active-low ready from slave mux (1 when no slave selected)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all sN_csn=1; req_ready=1; rsp_valid=0;
//   rsp_err=0; rsp_rdata=0; bus_addr/bus_wdata=0; bus_wr=0; timeout counter=0.
//  FSM states: IDLE, ACCESS, RESP.
//  IDLE: req_ready=1. On req_valid at clock edge: latch addr/wr/wdata into bus_* regs.
//   - req_addr[31]==1 -> decode miss: go RESP with err=1, no csn asserted.
//   - else go ACCESS with csn[req_addr[SEL_LSB+2:SEL_LSB]] driven low (registered).
//  ACCESS: req_ready=0; selected csn low, bus_* stable; counter increments each cycle.
//   - m_rdyn==0 at edge: capture m_rdata (reads only; writes capture 0), err=0, csn->1, go RESP.
//   - else if TIMEOUT!=0 and counter==TIMEOUT-1: err=1, rdata=0, csn->1, go RESP.
//   - m_rdyn==0 wins over timeout in the same cycle.
//  RESP: rsp_valid=1 for exactly one cycle with rsp_rdata/rsp_err; req_ready=0; counter
//   cleared; next state IDLE. Outside RESP rsp_valid=0; rsp_rdata/rsp_err hold last value.
//  Latency: request accepted at edge T -> csn low during cycle T+1; if m_rdyn low in
//   T+1, rsp_valid in T+2 (min 2 cycles). Decode miss: rsp_valid in T+1.
//  Back-to-back: next request acceptable in cycle after RESP (IDLE); min 3-cycle period.
//  All outputs registered; csn never glitches; exactly zero or one csn low at any time.
//  req_* inputs ignored outside IDLE. Reset mid-ACCESS releases csn immediately (async).
// TESTING
//  1 Read s2: req addr=0x2000_0010, rdyn low 1st ACCESS cycle, m_rdata=0xDEADBEEF ->
//    s2_csn low 1 cycle, rsp_valid at T+2, rdata=0xDEADBEEF, err=0.
//  2 Write s7 with 5 wait cycles: addr=0x7000_0004, wdata=0x1234_5678 -> s7_csn low 6
//    cycles, bus_wr=1 and wdata stable, rsp_valid err=0 rdata=0.
//  3 Timeout: TIMEOUT=4, read s0, m_rdyn stuck 1 -> s0_csn low exactly 4 cycles,
//    rsp_valid with err=1 rdata=0, next request accepted.
//  4 Decode miss: addr=0x8000_0000 -> no csn asserted, rsp_valid at T+1 with err=1.
//  5 Ready vs timeout tie: TIMEOUT=4, rdyn low in 4th ACCESS cycle -> err=0, data returned.
//  6 Async reset asserted mid-ACCESS -> all csn=1, rsp_valid=0, req_ready=1 before next edge.

Source files
------------

// File: rtl/bus_master_ctrl_if.sv
// CPU request/response and slave-bus signal bundle for bus_master_ctrl.
// The master modport is the controller's view; the slave modport is the CPU/slave-mux side.
interface bus_master_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] bus_addr;
    logic        bus_wr;
    logic [31:0] bus_wdata;
    logic        s0_csn;
    logic        s1_csn;
    logic        s2_csn;
    logic        s3_csn;
    logic        s4_csn;
    logic        s5_csn;
    logic        s6_csn;
    logic        s7_csn;
    logic [31:0] m_rdata;
    logic        m_rdyn;

    modport master (
        input  req_valid, req_addr, req_wr, req_wdata, m_rdata, m_rdyn,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_wr, bus_wdata,
        output s0_csn, s1_csn, s2_csn, s3_csn, s4_csn, s5_csn, s6_csn, s7_csn
    );

    modport slave (
        output req_valid, req_addr, req_wr, req_wdata, m_rdata, m_rdyn,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_wr, bus_wdata,
        input  s0_csn, s1_csn, s2_csn, s3_csn, s4_csn, s5_csn, s6_csn, s7_csn
    );
endinterface

// File: rtl/bus_master_ctrl.sv
// Single-outstanding bus master: decodes a CPU request onto one of eight active-low chip
// selects, waits for the muxed ready (or a timeout) and returns a one-cycle response.
module bus_master_ctrl #(
    parameter int unsigned SEL_LSB = 28,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic               clk,
    input  logic               rst,
    bus_master_ctrl_if.master  bus
);
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_SLV = 8;
    localparam int unsigned SEL_W   = 3;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t               r_state;
    logic [NUM_SLV-1:0]   r_csn;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic                 r_rsp_err;
    logic [DATA_W-1:0]    r_rsp_rdata;
    logic [ADDR_W-1:0]    r_bus_addr;
    logic                 r_bus_wr;
    logic [DATA_W-1:0]    r_bus_wdata;
    logic [CNT_W-1:0]     r_cnt;

    logic [SEL_W-1:0]     w_sel;
    logic                 w_timeout;

    assign w_sel     = bus.req_addr[SEL_LSB +: SEL_W];
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

    // Controller FSM; every output is a register so chip selects cannot glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_csn       <= '1;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_bus_addr  <= '0;
            r_bus_wr    <= 1'b0;
            r_bus_wdata <= '0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_bus_addr  <= bus.req_addr;
                        r_bus_wr    <= bus.req_wr;
                        r_bus_wdata <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        // Upper half of the address space has no slave behind it.
                        if (bus.req_addr[ADDR_W-1]) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state <= ST_ACCESS;
                            r_csn   <= ~(NUM_SLV'(1) << w_sel);
                        end
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Slave ready takes priority over a timeout in the same cycle.
                    if (!bus.m_rdyn) begin
                        r_state     <= ST_RESP;
                        r_csn       <= '1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_bus_wr ? '0 : bus.m_rdata;
                    end else if (w_timeout) begin
                        r_state     <= ST_RESP;
                        r_csn       <= '1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_cnt       <= '0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_csn       <= '1;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_cnt       <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wr    = r_bus_wr;
    assign bus.bus_wdata = r_bus_wdata;
    assign bus.s0_csn    = r_csn[0];
    assign bus.s1_csn    = r_csn[1];
    assign bus.s2_csn    = r_csn[2];
    assign bus.s3_csn    = r_csn[3];
    assign bus.s4_csn    = r_csn[4];
    assign bus.s5_csn    = r_csn[5];
    assign bus.s6_csn    = r_csn[6];
    assign bus.s7_csn    = r_csn[7];
endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed bench for bus_master_ctrl: a default-timeout instance (a) and a TIMEOUT=4
// instance (b) receive identical stimulus; vector table plus multi-cycle corner sequences.
module tb_bus_master_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic [31:0] req_addr  = '0;
    logic        req_wr    = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        m_rdyn    = 1'b1;
    logic [31:0] m_rdata   = '0;

    bus_master_ctrl_if ifa ();
    bus_master_ctrl_if ifb ();

    assign ifa.req_valid = req_valid;
    assign ifa.req_addr  = req_addr;
    assign ifa.req_wr    = req_wr;
    assign ifa.req_wdata = req_wdata;
    assign ifa.m_rdyn    = m_rdyn;
    assign ifa.m_rdata   = m_rdata;
    assign ifb.req_valid = req_valid;
    assign ifb.req_addr  = req_addr;
    assign ifb.req_wr    = req_wr;
    assign ifb.req_wdata = req_wdata;
    assign ifb.m_rdyn    = m_rdyn;
    assign ifb.m_rdata   = m_rdata;

    bus_master_ctrl dut_a (.clk(clk), .rst(rst), .bus(ifa));
    bus_master_ctrl #(.SEL_LSB(28), .TIMEOUT(4), .CNT_W(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    logic [7:0] csn_a, csn_b;
    assign csn_a = {ifa.s7_csn, ifa.s6_csn, ifa.s5_csn, ifa.s4_csn,
                    ifa.s3_csn, ifa.s2_csn, ifa.s1_csn, ifa.s0_csn};
    assign csn_b = {ifb.s7_csn, ifb.s6_csn, ifb.s5_csn, ifb.s4_csn,
                    ifb.s3_csn, ifb.s2_csn, ifb.s1_csn, ifb.s0_csn};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_addr  = '0;
        req_wr    = 1'b0;
        req_wdata = '0;
        m_rdyn    = 1'b1;
        m_rdata   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        vld;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        rdyn;
        logic [31:0] rdata;
        logic [7:0]  e_csn;
        logic        e_ready;
        logic        e_rvalid;
        logic        e_err;
        logic [31:0] e_rdata;
        logic [31:0] e_baddr;
        logic        e_bwr;
        logic [31:0] e_bwdata;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mkv(
        input logic vld, input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
        input logic rdyn, input logic [31:0] rdata,
        input logic [7:0] e_csn, input logic e_ready, input logic e_rvalid, input logic e_err,
        input logic [31:0] e_rdata, input logic [31:0] e_baddr, input logic e_bwr,
        input logic [31:0] e_bwdata);
        vec_t v;
        v.vld = vld; v.addr = addr; v.wr = wr; v.wdata = wdata; v.rdyn = rdyn; v.rdata = rdata;
        v.e_csn = e_csn; v.e_ready = e_ready; v.e_rvalid = e_rvalid; v.e_err = e_err;
        v.e_rdata = e_rdata; v.e_baddr = e_baddr; v.e_bwr = e_bwr; v.e_bwdata = e_bwdata;
        return v;
    endfunction

    int lo_a, lo_b, bad_a, bad_b;
    logic got_a, got_b, err_a, err_b;
    logic [31:0] rd_a, rd_b;

    initial begin
        // Inputs sampled at the edge; expected values are the registered outputs after it.
        //            vld addr          wr wdata         rdyn rdata          csn    rdy rv err rdata          baddr         bwr bwdata
        vecs[0]  = mkv(1, 32'h2000_0010, 0, 32'h0,        1, 32'h0,         8'hFB, 0, 0, 0, 32'h0,         32'h2000_0010, 0, 32'h0);
        vecs[1]  = mkv(0, 32'h0,         0, 32'h0,        0, 32'hDEAD_BEEF, 8'hFF, 0, 1, 0, 32'hDEAD_BEEF, 32'h2000_0010, 0, 32'h0);
        vecs[2]  = mkv(0, 32'h0,         0, 32'h0,        1, 32'h0,         8'hFF, 1, 0, 0, 32'hDEAD_BEEF, 32'h2000_0010, 0, 32'h0);
        vecs[3]  = mkv(1, 32'h8000_0000, 0, 32'h0,        1, 32'h0,         8'hFF, 0, 1, 1, 32'h0,         32'h8000_0000, 0, 32'h0);
        vecs[4]  = mkv(1, 32'h3000_0000, 0, 32'h0,        1, 32'h0,         8'hFF, 1, 0, 1, 32'h0,         32'h8000_0000, 0, 32'h0);
        vecs[5]  = mkv(1, 32'h5000_0000, 0, 32'h0,        1, 32'h0,         8'hDF, 0, 0, 1, 32'h0,         32'h5000_0000, 0, 32'h0);
        vecs[6]  = mkv(1, 32'h1000_0000, 1, 32'hAAAA_0000, 0, 32'hCAFE_F00D, 8'hFF, 0, 1, 0, 32'hCAFE_F00D, 32'h5000_0000, 0, 32'h0);
        vecs[7]  = mkv(0, 32'h0,         0, 32'h0,        1, 32'h0,         8'hFF, 1, 0, 0, 32'hCAFE_F00D, 32'h5000_0000, 0, 32'h0);
        vecs[8]  = mkv(1, 32'h7000_0004, 1, 32'h1234_5678, 1, 32'h0,        8'h7F, 0, 0, 0, 32'hCAFE_F00D, 32'h7000_0004, 1, 32'h1234_5678);
        for (int i = 9; i <= 13; i++)
            vecs[i] = mkv(0, 32'h0,      0, 32'h0,        1, 32'h0,         8'h7F, 0, 0, 0, 32'hCAFE_F00D, 32'h7000_0004, 1, 32'h1234_5678);
        vecs[14] = mkv(0, 32'h0,         0, 32'h0,        0, 32'hFFFF_FFFF, 8'hFF, 0, 1, 0, 32'h0,         32'h7000_0004, 1, 32'h1234_5678);
        vecs[15] = mkv(1, 32'h0000_0100, 0, 32'h0,        1, 32'h0,         8'hFF, 1, 0, 0, 32'h0,         32'h7000_0004, 1, 32'h1234_5678);
        vecs[16] = mkv(1, 32'h0000_0100, 0, 32'h0,        1, 32'h0,         8'hFE, 0, 0, 0, 32'h0,         32'h0000_0100, 0, 32'h0);
        vecs[17] = mkv(0, 32'h0,         0, 32'h0,        0, 32'h0BAD_C0DE, 8'hFF, 0, 1, 0, 32'h0BAD_C0DE, 32'h0000_0100, 0, 32'h0);
        vecs[18] = mkv(0, 32'h0,         0, 32'h0,        1, 32'h0,         8'hFF, 1, 0, 0, 32'h0BAD_C0DE, 32'h0000_0100, 0, 32'h0);

        do_reset();
        check("reset csn",       32'(csn_a),          32'h0000_00FF);
        check("reset req_ready", 32'(ifa.req_ready),  32'd1);
        check("reset rsp_valid", 32'(ifa.rsp_valid),  32'd0);
        check("reset rsp_err",   32'(ifa.rsp_err),    32'd0);
        check("reset rsp_rdata", ifa.rsp_rdata,       32'h0);
        check("reset bus_addr",  ifa.bus_addr,        32'h0);
        check("reset bus_wr",    32'(ifa.bus_wr),     32'd0);
        check("reset bus_wdata", ifa.bus_wdata,       32'h0);

        for (int k = 0; k < NV; k++) begin
            req_valid = vecs[k].vld;
            req_addr  = vecs[k].addr;
            req_wr    = vecs[k].wr;
            req_wdata = vecs[k].wdata;
            m_rdyn    = vecs[k].rdyn;
            m_rdata   = vecs[k].rdata;
            tick();
            check($sformatf("v%0d csn", k),       32'(csn_a),         32'(vecs[k].e_csn));
            check($sformatf("v%0d req_ready", k), 32'(ifa.req_ready), 32'(vecs[k].e_ready));
            check($sformatf("v%0d rsp_valid", k), 32'(ifa.rsp_valid), 32'(vecs[k].e_rvalid));
            check($sformatf("v%0d rsp_err", k),   32'(ifa.rsp_err),   32'(vecs[k].e_err));
            check($sformatf("v%0d rsp_rdata", k), ifa.rsp_rdata,      vecs[k].e_rdata);
            check($sformatf("v%0d bus_addr", k),  ifa.bus_addr,       vecs[k].e_baddr);
            check($sformatf("v%0d bus_wr", k),    32'(ifa.bus_wr),    32'(vecs[k].e_bwr));
            check($sformatf("v%0d bus_wdata", k), ifa.bus_wdata,      vecs[k].e_bwdata);
        end

        // Timeout with m_rdyn stuck high: b gives up after 4 cycles, a after 256.
        do_reset();
        req_valid = 1'b1;
        req_addr  = 32'h1000_0040;
        lo_a = 0; lo_b = 0; bad_a = 0; bad_b = 0;
        got_a = 1'b0; got_b = 1'b0; err_a = 1'b0; err_b = 1'b0; rd_a = '1; rd_b = '1;
        for (int c = 0; c < 300; c++) begin
            tick();
            req_valid = 1'b0;
            if (csn_a == 8'hFD) lo_a++; else if (csn_a != 8'hFF) bad_a++;
            if (csn_b == 8'hFD) lo_b++; else if (csn_b != 8'hFF) bad_b++;
            if (ifa.rsp_valid && !got_a) begin got_a = 1'b1; err_a = ifa.rsp_err; rd_a = ifa.rsp_rdata; end
            if (ifb.rsp_valid && !got_b) begin got_b = 1'b1; err_b = ifb.rsp_err; rd_b = ifb.rsp_rdata; end
        end
        check("to4 csn low cycles",   32'(lo_b),  32'd4);
        check("to4 stray csn",        32'(bad_b), 32'd0);
        check("to4 rsp seen",         32'(got_b), 32'd1);
        check("to4 rsp_err",          32'(err_b), 32'd1);
        check("to4 rsp_rdata",        rd_b,       32'h0);
        check("to256 csn low cycles", 32'(lo_a),  32'd256);
        check("to256 stray csn",      32'(bad_a), 32'd0);
        check("to256 rsp seen",       32'(got_a), 32'd1);
        check("to256 rsp_err",        32'(err_a), 32'd1);
        check("to256 rsp_rdata",      rd_a,       32'h0);

        // Both instances must accept a fresh request after a timeout.
        check("after to req_ready", 32'(ifb.req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = 32'h4000_0000;
        tick();
        check("after to csn b", 32'(csn_b), 32'h0000_00EF);
        check("after to csn a", 32'(csn_a), 32'h0000_00EF);
        idle_inputs();
        m_rdyn  = 1'b0;
        m_rdata = 32'h55AA_55AA;
        tick();
        check("after to rsp_valid", 32'(ifb.rsp_valid), 32'd1);
        check("after to rsp_err",   32'(ifb.rsp_err),   32'd0);
        check("after to rsp_rdata", ifb.rsp_rdata,      32'h55AA_55AA);
        idle_inputs();
        tick();

        // Ready arriving in the same cycle the 4-cycle timeout would fire.
        do_reset();
        req_valid = 1'b1;
        req_addr  = 32'h6000_0000;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        check("tie csn before last", 32'(csn_b),         32'h0000_00BF);
        check("tie no early rsp",    32'(ifb.rsp_valid), 32'd0);
        m_rdyn  = 1'b0;
        m_rdata = 32'h600D_DA7A;
        tick();
        check("tie rsp_valid", 32'(ifb.rsp_valid), 32'd1);
        check("tie rsp_err",   32'(ifb.rsp_err),   32'd0);
        check("tie rsp_rdata", ifb.rsp_rdata,      32'h600D_DA7A);
        check("tie csn",       32'(csn_b),         32'h0000_00FF);
        idle_inputs();
        tick();

        // Asynchronous reset in the middle of an access.
        req_valid = 1'b1;
        req_addr  = 32'h3000_0000;
        tick();
        check("pre-rst csn", 32'(csn_a), 32'h0000_00F7);
        req_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async rst csn a",     32'(csn_a),         32'h0000_00FF);
        check("async rst csn b",     32'(csn_b),         32'h0000_00FF);
        check("async rst req_ready", 32'(ifa.req_ready), 32'd1);
        check("async rst rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        check("async rst bus_addr",  ifa.bus_addr,       32'h0);
        #1 rst = 1'b0;
        tick();
        check("post-rst csn",       32'(csn_a),         32'h0000_00FF);
        check("post-rst req_ready", 32'(ifa.req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
